sr_latch_sequencer: RTL and testbench



---
 rtl/sr_ctrl_pkg.sv | 26 ++
 rtl/sr_pulse_timer.sv | 35 +++
 rtl/sr_latch_sequencer.sv | 137 +++++++++++++
 tb/tb_sr_latch_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_ctrl_pkg.sv
// rtl/sr_ctrl_pkg.sv - shared types and constants for the S/R latch sequencer
package sr_ctrl_pkg;

    localparam logic [1:0] SR_OP_NOP    = 2'b00;
    localparam logic [1:0] SR_OP_SET    = 2'b01;
    localparam logic [1:0] SR_OP_RESET  = 2'b10;
    localparam logic [1:0] SR_OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        OP_NOP    = SR_OP_NOP,
        OP_SET    = SR_OP_SET,
        OP_RESET  = SR_OP_RESET,
        OP_TOGGLE = SR_OP_TOGGLE
    } sr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GUARD
    } sr_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// rtl/sr_pulse_timer.sv - loadable down-counter timing PULSE and GUARD intervals
module sr_pulse_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // done marks the last cycle of the loaded interval (count reaches 1)
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == W'(1));

endmodule

// File: rtl/sr_latch_sequencer.sv
// rtl/sr_latch_sequencer.sv - one-at-a-time S/R pulse sequencer with shadow latch state
module sr_latch_sequencer
    import sr_ctrl_pkg::*;
#(
    parameter int N            = 8,
    parameter int PULSE_CYCLES = 2,
    parameter int GUARD_CYCLES = 1,
    localparam int IDX_W       = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [IDX_W-1:0] cmd_idx,
    output logic [N-1:0]     s_out,
    output logic [N-1:0]     r_out,
    output logic [N-1:0]     shadow_q,
    output logic             busy,
    output logic             err_idx
);

    localparam int CNT_W = $clog2(max_u(PULSE_CYCLES, GUARD_CYCLES) + 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYCLES);
    localparam logic [IDX_W:0]   N_LIM    = (IDX_W + 1)'(N);

    sr_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             set_q, set_d;
    logic [N-1:0]     s_q, s_d;
    logic [N-1:0]     r_q, r_d;
    logic [N-1:0]     shadow_d;
    logic             err_q, err_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;

    sr_op_e           op;
    logic             bad_idx;
    logic             to_set;
    logic [N-1:0]     one_hot;

    sr_pulse_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // TOGGLE is resolved against the shadow at accept time, so the pulse is always a plain S or R
    always_comb begin
        op      = sr_op_e'(cmd_op);
        bad_idx = ({1'b0, cmd_idx} >= N_LIM);
        to_set  = (op == OP_SET) || ((op == OP_TOGGLE) && !shadow_q[cmd_idx]);
        one_hot = '0;
        one_hot[cmd_idx] = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        set_d    = set_q;
        s_d      = s_q;
        r_d      = r_q;
        shadow_d = shadow_q;
        err_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (bad_idx) begin
                        err_d = 1'b1;
                    end else if (op != OP_NOP) begin
                        state_d  = ST_PULSE;
                        idx_d    = cmd_idx;
                        set_d    = to_set;
                        s_d      = to_set ? one_hot : '0;
                        r_d      = to_set ? '0 : one_hot;
                        tmr_load = 1'b1;
                        tmr_val  = PULSE_LD;
                    end
                end
            end
            ST_PULSE: begin
                if (tmr_done) begin
                    state_d         = ST_GUARD;
                    s_d             = '0;
                    r_d             = '0;
                    shadow_d[idx_q] = set_q;
                    tmr_load        = 1'b1;
                    tmr_val         = GUARD_LD;
                end
            end
            ST_GUARD: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
                r_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            set_q    <= 1'b0;
            s_q      <= '0;
            r_q      <= '0;
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            set_q    <= set_d;
            s_q      <= s_d;
            r_q      <= r_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign s_out     = s_q;
    assign r_out     = r_q;
    assign err_idx   = err_q;

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// tb/tb_sr_latch_sequencer.sv - self-checking bench for sr_latch_sequencer
module tb_sr_latch_sequencer;

    localparam int N  = 8;
    localparam int P  = 2;
    localparam int G  = 1;
    localparam int NB = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_idx;
    logic [7:0] s_out, r_out, shadow_q;
    logic       busy, err_idx;

    logic       b_valid, b_ready, b_busy, b_err;
    logic [1:0] b_op;
    logic [2:0] b_idx;
    logic [4:0] b_s, b_r, b_shadow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] s;
        logic [7:0] r;
        logic [7:0] sh;
    } exp_t;
    exp_t sb[$];

    sr_latch_sequencer #(.N(N), .PULSE_CYCLES(P), .GUARD_CYCLES(G)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_idx(cmd_idx), .s_out(s_out), .r_out(r_out),
        .shadow_q(shadow_q), .busy(busy), .err_idx(err_idx)
    );

    sr_latch_sequencer #(.N(NB), .PULSE_CYCLES(P), .GUARD_CYCLES(G)) dut_b (
        .clk(clk), .reset(reset), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_op(b_op), .cmd_idx(b_idx), .s_out(b_s), .r_out(b_r),
        .shadow_q(b_shadow), .busy(b_busy), .err_idx(b_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_checks++;
        if ((s_out & r_out) != 0 || $countones(s_out | r_out) > 1 || ((s_out | r_out) != 0 && !busy)) begin
            n_fail++;
            $display("FAIL invariant_a: s_out=%h r_out=%h busy=%b, required disjoint one-hot lines only while busy", s_out, r_out, busy);
        end
        n_checks++;
        if ((b_s & b_r) != 0 || $countones(b_s | b_r) > 1 || ((b_s | b_r) != 0 && !b_busy)) begin
            n_fail++;
            $display("FAIL invariant_b: s_out=%h r_out=%h busy=%b, required disjoint one-hot lines only while busy", b_s, b_r, b_busy);
        end
    end

    task automatic issue(input logic [1:0] op, input logic [2:0] idx);
        cmd_op    = op;
        cmd_idx   = idx;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_idx   = 3'd2;
        b_valid   = 1'b1;
        b_op      = 2'b01;
        b_idx     = 3'd1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (s_out !== 8'h00 || r_out !== 8'h00 || shadow_q !== 8'h00 || err_idx !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: s=%h r=%h sh=%h err=%b busy=%b, required all zero", s_out, r_out, shadow_q, err_idx, busy);
        end
        cmd_valid = 1'b0;
        b_valid   = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || b_ready !== 1'b1 || shadow_q !== 8'h00 || b_shadow !== 5'h00) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b b_ready=%b sh=%h b_sh=%h, required ready=1 shadow=0", cmd_ready, b_ready, shadow_q, b_shadow);
        end
    endtask

    task automatic test_set();
        logic [7:0] exp_s;
        @(negedge clk);
        issue(2'b01, 3'd3);
        for (int c = 1; c <= P + G + 1; c++) begin
            @(negedge clk);
            exp_s = (c <= P) ? 8'h08 : 8'h00;
            n_checks++;
            if (s_out !== exp_s || r_out !== 8'h00) begin
                n_fail++;
                $display("FAIL set_lines c%0d: s=%h r=%h, required s=%h r=00", c, s_out, r_out, exp_s);
            end
            n_checks++;
            if (cmd_ready !== (c == P + G + 1)) begin
                n_fail++;
                $display("FAIL set_ready c%0d: ready=%b, required %b", c, cmd_ready, (c == P + G + 1));
            end
            if (c > P) begin
                n_checks++;
                if (shadow_q !== 8'h08) begin
                    n_fail++;
                    $display("FAIL set_shadow c%0d: shadow=%h, required 08", c, shadow_q);
                end
            end
        end
    endtask

    task automatic test_toggle();
        logic [7:0] exp_s, exp_r, exp_sh;
        for (int pass = 0; pass < 2; pass++) begin
            issue(2'b11, 3'd3);
            exp_sh = (pass == 0) ? 8'h00 : 8'h08;
            for (int c = 1; c <= P + G + 1; c++) begin
                @(negedge clk);
                exp_s = (c <= P && pass == 1) ? 8'h08 : 8'h00;
                exp_r = (c <= P && pass == 0) ? 8'h08 : 8'h00;
                n_checks++;
                if (s_out !== exp_s || r_out !== exp_r) begin
                    n_fail++;
                    $display("FAIL toggle%0d_lines c%0d: s=%h r=%h, required s=%h r=%h", pass, c, s_out, r_out, exp_s, exp_r);
                end
                if (c > P) begin
                    n_checks++;
                    if (shadow_q !== exp_sh) begin
                        n_fail++;
                        $display("FAIL toggle%0d_shadow c%0d: shadow=%h, required %h", pass, c, shadow_q, exp_sh);
                    end
                end
            end
        end
    endtask

    task automatic test_bad_idx();
        b_op    = 2'b01;
        b_idx   = 3'd5;
        b_valid = 1'b1;
        cmd_op  = 2'b00;
        cmd_idx = 3'd2;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        b_valid   = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (b_err !== 1'b1 || b_s !== 5'h00 || b_r !== 5'h00 || b_shadow !== 5'h00 || b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_idx_c1: err=%b s=%h r=%h sh=%h ready=%b, required err=1 lines=0 sh=0 ready=1", b_err, b_s, b_r, b_shadow, b_ready);
        end
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || s_out !== 8'h00 || r_out !== 8'h00 || shadow_q !== 8'h08 || err_idx !== 1'b0) begin
            n_fail++;
            $display("FAIL nop_c1: ready=%b busy=%b s=%h r=%h sh=%h err=%b, required idle with sh=08", cmd_ready, busy, s_out, r_out, shadow_q, err_idx);
        end
        b_idx   = 3'd4;
        b_valid = 1'b1;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (b_err !== 1'b0 || b_s !== 5'h10) begin
            n_fail++;
            $display("FAIL last_idx_c1: err=%b s=%h, required err=0 s=10", b_err, b_s);
        end
        repeat (P + G) @(negedge clk);
        n_checks++;
        if (b_shadow !== 5'h10 || b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL last_idx_done: sh=%h ready=%b, required sh=10 ready=1", b_shadow, b_ready);
        end
    endtask

    task automatic test_back_to_back();
        int  gap = 0;
        bit  saw_s = 0;
        bit  saw_zero = 0;
        @(negedge clk);
        cmd_op    = 2'b01;
        cmd_idx   = 3'd0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_op = 2'b10;
        for (int c = 1; c <= 12 && gap == 0; c++) begin
            @(negedge clk);
            if (s_out[0]) saw_s = 1;
            if (saw_s && (s_out | r_out) == 8'h00) saw_zero = 1;
            if (cmd_ready) gap = c;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n_checks++;
        if (gap != P + G + 1) begin
            n_fail++;
            $display("FAIL b2b_gap: accepts %0d cycles apart, required %0d", gap, P + G + 1);
        end
        n_checks++;
        if (!saw_s || !saw_zero) begin
            n_fail++;
            $display("FAIL b2b_zero: saw_s=%0d saw_zero=%0d, required both 1", saw_s, saw_zero);
        end
        for (int c = 1; c <= P + 1; c++) begin
            @(negedge clk);
            n_checks++;
            if (r_out !== ((c <= P) ? 8'h01 : 8'h00) || s_out !== 8'h00) begin
                n_fail++;
                $display("FAIL b2b_reset_line c%0d: s=%h r=%h, required r=%h", c, s_out, r_out, (c <= P) ? 8'h01 : 8'h00);
            end
        end
        n_checks++;
        if (shadow_q !== 8'h08) begin
            n_fail++;
            $display("FAIL b2b_shadow: shadow=%h, required 08", shadow_q);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        issue(2'b01, 3'd5);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (s_out !== 8'h20) begin
            n_fail++;
            $display("FAIL mid_pulse: s=%h, required 20", s_out);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s_out !== 8'h00 || r_out !== 8'h00 || shadow_q !== 8'h00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: s=%h r=%h sh=%h busy=%b, required all zero", s_out, r_out, shadow_q, busy);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || shadow_q !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_release: ready=%b sh=%h, required ready=1 sh=00", cmd_ready, shadow_q);
        end
    endtask

    task automatic test_random();
        logic [7:0] m = 8'h00;
        logic [7:0] prev = 8'h00;
        logic [7:0] oh;
        logic       nv;
        exp_t       e;
        for (int i = 0; i < 230; i++) begin
            @(negedge clk);
            if (prev == 8'h00 && (s_out | r_out) != 8'h00) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_line: unexpected pulse s=%h r=%h, required no pulse", s_out, r_out);
                end else if (s_out !== sb[0].s || r_out !== sb[0].r) begin
                    n_fail++;
                    $display("FAIL rand_line: s=%h r=%h, required s=%h r=%h", s_out, r_out, sb[0].s, sb[0].r);
                end
            end
            if (prev != 8'h00 && (s_out | r_out) == 8'h00 && sb.size() != 0) begin
                e = sb.pop_front();
                n_checks++;
                if (shadow_q !== e.sh) begin
                    n_fail++;
                    $display("FAIL rand_shadow: shadow=%h, required %h", shadow_q, e.sh);
                end
            end
            prev = s_out | r_out;
            if (i < 200) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_idx   = 3'($urandom_range(0, 7));
            end else begin
                cmd_valid = 1'b0;
            end
            if (cmd_valid && cmd_ready && cmd_op != 2'b00) begin
                nv = (cmd_op == 2'b01) ? 1'b1 : (cmd_op == 2'b10) ? 1'b0 : ~m[cmd_idx];
                oh = 8'h00;
                oh[cmd_idx] = 1'b1;
                m[cmd_idx] = nv;
                e.s  = nv ? oh : 8'h00;
                e.r  = nv ? 8'h00 : oh;
                e.sh = m;
                sb.push_back(e);
            end
        end
        n_checks++;
        if (sb.size() != 0 || shadow_q !== m) begin
            n_fail++;
            $display("FAIL rand_final: pending=%0d shadow=%h, required pending=0 shadow=%h", sb.size(), shadow_q, m);
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_idx   = 3'd0;
        b_valid   = 1'b0;
        b_op      = 2'b00;
        b_idx     = 3'd0;
        test_reset();
        test_set();
        test_toggle();
        test_bad_idx();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
